// File: rtl/stack_access_arbiter_pkg.sv
// Shared definitions for the two-requester stack arbiter and its requesting controllers.
package stack_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam logic [7:0] SEP_CHAR = 8'h3b;
  localparam logic [7:0] END_CHAR = 8'h24;

endpackage

// File: rtl/stack_access_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: rr names the favoured requester, the other wins only if rr is idle.
module rr_arbiter2 (
  input  logic [1:0] elig,
  input  logic       rr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (elig[rr]) begin
      gnt[rr] = 1'b1;
    end else if (elig[~rr]) begin
      gnt[~rr] = 1'b1;
    end
  end

endmodule

// File: rtl/stack_access_arbiter.sv
// Shares one single-port stack RAM between two requesters; owns the stack pointer,
// grants at most one push or pop per cycle with round-robin priority and an optional burst lock.
module stack_access_arbiter
  import stack_access_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_pop,
  input  logic [1:0]              req_lock,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              gnt,
  output logic                    rd_valid,
  output logic                    rd_owner,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [ADDR_WIDTH:0]     count,
  output logic                    full,
  output logic                    empty
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE_CNT   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  arb_state_t          state, state_nxt;
  logic [ADDR_WIDTH:0] sp, sp_dec;
  logic                rr;
  logic [1:0]          elig, arb_gnt;
  logic                lock_hold, lock_owner;
  logic                granted, gnt_idx, gnt_pop;

  assign count  = sp;
  assign full   = (sp == DEPTH_CNT);
  assign empty  = (sp == '0);
  assign sp_dec = sp - ONE_CNT;

  // Eligibility only looks at the registered count, so a blocked request simply waits.
  assign elig[0] = req_valid[0] & ((req_pop[0] == OP_POP) ? !empty : !full);
  assign elig[1] = req_valid[1] & ((req_pop[1] == OP_POP) ? !empty : !full);

  rr_arbiter2 u_rr (
    .elig (elig),
    .rr   (rr),
    .gnt  (arb_gnt)
  );

  assign lock_owner = (state == LOCK1);
  assign lock_hold  = ((state == LOCK0) && req_lock[0]) || ((state == LOCK1) && req_lock[1]);

  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      if (lock_hold) begin
        gnt[lock_owner] = elig[lock_owner];
      end else begin
        gnt = arb_gnt;
      end
    end
  end

  assign granted = |gnt;
  assign gnt_idx = gnt[1];
  assign gnt_pop = req_pop[gnt_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  // A dropped lock behaves exactly like ARB for that cycle, including the next-state choice.
  always_comb begin
    state_nxt = state;
    if (!lock_hold) begin
      if (granted && req_lock[gnt_idx]) begin
        state_nxt = gnt_idx ? LOCK1 : LOCK0;
      end else begin
        state_nxt = ARB;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      mem_addr = sp_dec[ADDR_WIDTH-1:0];
      if (granted && (gnt_pop == OP_PUSH)) begin
        mem_we    = 1'b1;
        mem_addr  = sp[ADDR_WIDTH-1:0];
        mem_wdata = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp       <= '0;
      rr       <= 1'b0;
      rd_valid <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_valid <= granted && (gnt_pop == OP_POP);
      if (granted) begin
        sp <= (gnt_pop == OP_POP) ? sp_dec : sp + ONE_CNT;
        if (!lock_hold) begin
          rr <= ~gnt_idx;
        end
        if (gnt_pop == OP_POP) begin
          rd_owner <= gnt_idx;
        end
      end
    end
  end

  assign rd_data = mem_rdata;

endmodule

// File: tb/tb_stack_access_arbiter.sv
// Directed bench for stack_access_arbiter with a behavioural synchronous RAM attached.
module tb_stack_access_arbiter;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid, req_pop, req_lock;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    gnt;
  logic          rd_valid, rd_owner;
  logic [DW-1:0] rd_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [AW:0]   count;
  logic          full, empty;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ram [DEPTH];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  stack_access_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_pop(req_pop),
    .req_lock(req_lock), .req_wdata(req_wdata), .gnt(gnt), .rd_valid(rd_valid),
    .rd_owner(rd_owner), .rd_data(rd_data), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .count(count), .full(full), .empty(empty)
  );

  // Advance one clock; returns on the falling edge, where inputs change and outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00; req_pop = 2'b00; req_lock = 2'b00; req_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    req_valid = 2'b11;
    #1;
    checks++;
    if (gnt !== 2'b00 || mem_we !== 1'b0) begin
      errors++; $display("FAIL reset_gnt gnt=%b we=%b expected gnt=00 we=0", gnt, mem_we);
    end
    step();
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state count=%0d empty=%b full=%b rd_valid=%b expected 0/1/0/0", count, empty, full, rd_valid);
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single();
    logic [DW-1:0] items [3];
    items[0] = 8'h41; items[1] = 8'h42; items[2] = 8'h43;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_valid = 2'b01; req_pop = 2'b00; req_wdata = {8'h00, items[i]};
      #1;
      checks++;
      if (gnt !== 2'b01 || mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== items[i]) begin
        errors++;
        $display("FAIL single_push%0d gnt=%b we=%b addr=%0d wdata=%h expected 01/1/%0d/%h", i, gnt, mem_we, mem_addr, mem_wdata, i, items[i]);
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      req_valid = 2'b01; req_pop = 2'b01;
      #1;
      checks++;
      if (gnt !== 2'b01 || mem_we !== 1'b0 || mem_addr !== AW'(2 - i)) begin
        errors++;
        $display("FAIL single_pop_gnt%0d gnt=%b we=%b addr=%0d expected 01/0/%0d", i, gnt, mem_we, mem_addr, 2 - i);
      end
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_owner !== 1'b0 || rd_data !== items[2 - i]) begin
        errors++;
        $display("FAIL single_pop_data%0d rd_valid=%b owner=%b data=%h expected 1/0/%h", i, rd_valid, rd_owner, rd_data, items[2 - i]);
      end
    end
    idle_inputs();
    step();
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL single_end count=%0d empty=%b rd_valid=%b expected 0/1/0", count, empty, rd_valid);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_gnt;
    do_reset();
    req_valid = 2'b11; req_pop = 2'b00; req_wdata = {8'hb0, 8'ha0};
    for (int i = 0; i < DEPTH; i++) begin
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if (gnt !== exp_gnt) begin
        errors++; $display("FAIL contention_gnt%0d gnt=%b expected %b", i, gnt, exp_gnt);
      end
      step();
      checks++;
      if (count !== 5'(i + 1)) begin
        errors++; $display("FAIL contention_count%0d count=%0d expected %0d", i, count, i + 1);
      end
    end
    #1;
    checks++;
    if (gnt !== 2'b00 || full !== 1'b1 || mem_we !== 1'b0) begin
      errors++; $display("FAIL contention_full gnt=%b full=%b we=%b expected 00/1/0", gnt, full, mem_we);
    end
    step();
    checks++;
    if (count !== 5'd16) begin
      errors++; $display("FAIL contention_hold count=%0d expected 16", count);
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    req_valid = 2'b11; req_pop = 2'b00; req_lock = 2'b01; req_wdata = {8'h22, 8'h11};
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (gnt !== 2'b01) begin
        errors++; $display("FAIL lock_burst%0d gnt=%b expected 01", i, gnt);
      end
      step();
    end
    req_lock = 2'b00;
    #1;
    checks++;
    if (gnt !== 2'b10 || mem_wdata !== 8'h22) begin
      errors++; $display("FAIL lock_release gnt=%b wdata=%h expected 10/22", gnt, mem_wdata);
    end
    step();
    checks++;
    if (count !== 5'd5) begin
      errors++; $display("FAIL lock_count count=%0d expected 5", count);
    end
    idle_inputs();
  endtask

  task automatic test_eligibility();
    do_reset();
    req_valid = 2'b11; req_pop = 2'b01; req_wdata = {8'h77, 8'h00};
    #1;
    checks++;
    if (gnt !== 2'b10) begin
      errors++; $display("FAIL elig_empty gnt=%b expected 10", gnt);
    end
    step();
    req_valid = 2'b01; req_pop = 2'b00; req_wdata = {8'h00, 8'h55};
    for (int i = 1; i < DEPTH; i++) step();
    checks++;
    if (count !== 5'd16 || full !== 1'b1) begin
      errors++; $display("FAIL elig_fill count=%0d full=%b expected 16/1", count, full);
    end
    req_valid = 2'b11; req_pop = 2'b10;
    #1;
    checks++;
    if (gnt !== 2'b10) begin
      errors++; $display("FAIL elig_full gnt=%b expected 10", gnt);
    end
    step();
    checks++;
    if (count !== 5'd15 || full !== 1'b0 || rd_valid !== 1'b1 || rd_owner !== 1'b1 || rd_data !== 8'h55) begin
      errors++;
      $display("FAIL elig_full_pop count=%0d full=%b rd_valid=%b owner=%b data=%h expected 15/0/1/1/55", count, full, rd_valid, rd_owner, rd_data);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 2'b01; req_pop = 2'b00;
    for (int i = 0; i < 5; i++) begin
      req_wdata = {8'h00, 8'(8'h60 + i)};
      step();
    end
    req_pop = 2'b01;
    #1;
    checks++;
    if (gnt !== 2'b01 || mem_addr !== 4'd4 || count !== 5'd5) begin
      errors++; $display("FAIL midrst_pop gnt=%b addr=%0d count=%0d expected 01/4/5", gnt, mem_addr, count);
    end
    step();
    reset = 1'b1;
    idle_inputs();
    step();
    checks++;
    if (rd_valid !== 1'b0 || count !== 5'd0) begin
      errors++; $display("FAIL midrst_state rd_valid=%b count=%0d expected 0/0", rd_valid, count);
    end
    reset = 1'b0;
    req_valid = 2'b01; req_pop = 2'b00; req_wdata = {8'h00, 8'h99};
    #1;
    checks++;
    if (gnt !== 2'b01 || mem_addr !== 4'd0 || mem_we !== 1'b1) begin
      errors++; $display("FAIL midrst_resume gnt=%b addr=%0d we=%b expected 01/0/1", gnt, mem_addr, mem_we);
    end
    step();
    req_pop = 2'b01;
    step();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h99 || count !== 5'd0) begin
      errors++; $display("FAIL midrst_readback rd_valid=%b data=%h count=%0d expected 1/99/0", rd_valid, rd_data, count);
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_eligibility();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_access_arbiter.md
Name: stack_access_arbiter

Overview:
- Arbitrates one shared single-port stack RAM between two requesters, e.g. two LIFO controllers serving alternate passengers' things.
- Owns the stack pointer and drives the RAM write-enable, address and write data.
- Each cycle, grants at most one push or pop, using round-robin priority.
- Supports an optional lock so one requester can run an uninterrupted burst of pushes or pops.

Parameters:
DATA_WIDTH, 8, width of one stacked item (character byte)
DEPTH, 16, stack entries
ADDR_WIDTH, 4, log2(DEPTH)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous reset, active high
req_valid  input  2  per-requester request (bit n = requester n)
req_pop  input  2  per-requester op: 0 = push, 1 = pop
req_lock  input  2  per-requester lock hold
req_wdata  input  2*DATA_WIDTH  push data; requester n in bits [n*DATA_WIDTH +: DATA_WIDTH]
gnt  output  2  one-hot/zero grant, combinational
rd_valid  output  1  pop data valid, one cycle after pop grant
rd_owner  output  1  requester index that owns rd_data
rd_data  output  DATA_WIDTH  popped item
mem_we  output  1  RAM write enable
mem_addr  output  ADDR_WIDTH  RAM address
mem_wdata  output  DATA_WIDTH  RAM write data
mem_rdata  input  DATA_WIDTH  RAM read data, synchronous, 1-cycle latency
count  output  ADDR_WIDTH+1  occupied entries (= stack pointer)
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:

Registers and reset:
- State registers: sp (stack pointer), rr (round-robin priority pointer), state, rd_valid, rd_owner.
- reset (sync) -> sp=0, rr=0, state=ARB, rd_valid=0, rd_owner=0.
- gnt, mem_we, mem_addr and mem_wdata are combinational; they read 0 while reset is high.

Eligibility (from the registered count only):
- elig[n] = req_valid[n] & (req_pop[n] ? !empty : !full).
- An ineligible request is not granted. It is backpressure, not an error; the requester holds it.

States:
- ARB:
  - Grant rr if elig[rr], else grant the other requester if eligible, else no grant.
  - On a grant to n: rr <= ~n. If req_lock[n]=1, next state is LOCKn; otherwise stay in ARB.
- LOCK0 / LOCK1 (owner n):
  - If req_lock[n]=1: only n may be granted (when elig[n]); the other requester always sees gnt=0. rr is not updated. Stay in LOCKn.
  - If req_lock[n]=0 in a cycle: that cycle arbitrates exactly as ARB, and the next state follows the ARB rules.
  - A lock cycle with no eligible request from the owner keeps the lock and gives no grant.

Granted push by n:
- mem_we=1, mem_addr=sp[ADDR_WIDTH-1:0], mem_wdata = requester n's data.
- sp <= sp+1.

Granted pop by n:
- mem_we=0, mem_addr=sp-1, sp <= sp-1.
- Next cycle: rd_valid=1, rd_owner=n, rd_data=mem_rdata (passthrough of the RAM output).

Idle cycles:
- No grant -> mem_we=0, mem_addr holds sp-1 (don't-care), rd_valid=0 next cycle.

Boundaries:
- Push while full and pop while empty are never granted, so sp never wraps.
- At count=DEPTH-1 a push grant makes full=1 in the next cycle.
- Back-to-back push then pop returns the just-written item (the RAM is write-first on a different cycle, so there is no hazard).
- Requests from both requesters in one cycle: exactly one grant.
- Reset while a pop is outstanding: rd_valid=0 in the following cycle and the data is discarded.
- Requester 0 pushing while requester 1 pops on an empty stack: the push is granted (the pop is ineligible).

Decomposition:
- Shared package: the state encoding (ARB=2'd0, LOCK0=2'd1, LOCK1=2'd2), the OP_PUSH/OP_POP constants, and the separator/end characters (8'h3b, 8'h24) used by the requesting controllers.
- Natural sub-module: rr_arbiter2, a 2-way round-robin pick from elig and rr producing a one-hot grant. The stack pointer and lock FSM stay in the top module.

Test Plan:
- Single requester: req0 pushes 8'h41, 8'h42, 8'h43, then pops 3 -> gnt[0] every cycle; rd_data 8'h43, 8'h42, 8'h41 with rd_owner=0; count returns to 0 and empty=1.
- Contention: both requesters push continuously from reset -> grants alternate 0,1,0,1; count increments by one per cycle until full at 16; after that gnt=0 and full=1.
- Lock: req0 pushes 4 items with req_lock[0]=1 while req1 also requests -> gnt[1]=0 for all 4 cycles. req_lock[0] drops with both requesting and rr=1 -> req1 granted that cycle.
- Empty/full eligibility: empty stack, req0 pop and req1 push -> req1 granted. Full stack, req0 push and req1 pop -> req1 granted; count goes from 16 to 15.
- Reset mid-operation: pop granted at count=5, reset asserted the next cycle -> rd_valid=0 and count=0, then normal operation resumes on the next push.
